alu_result_display: RTL

Downstream stage of the 8-bit ALU on the Mimas V2 board. Samples the ALU's 8-bit result, converts it to three BCD digits with a sequential double-dabble engine, and drives the 3-digit common-anode seven-segment display with time-multiplexed, active-low segment and digit-enable lines.

---
 rtl/alu_display_pkg.sv | 46 ++++
 rtl/alu_result_display_if.sv | 17 +
 rtl/bin_to_bcd.sv | 78 +++++++
 rtl/alu_result_display.sv | 106 ++++++++++
 4 files changed

// File: rtl/alu_display_pkg.sv
// Shared definitions for the ALU result display.
// Contents: the conversion FSM state type, the digit count, the active-low
// seven-segment codes ({a,b,c,d,e,f,g,dp}, dp off) and a nibble-to-segment decoder.
package alu_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } conv_state_t;

    localparam int NUM_DIGITS = 3;

    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Nibbles above 9 never occur in valid BCD; they go dark rather than
    // showing garbage.
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_result_display_if.sv
// Bundle between the ALU and the display stage.
//   i_Result : ALU result, unsigned (ALU -> display)
//   o_Seg    : segments, active-low, [7:1]=a..g, [0]=dp
//   o_Enable : digit enables, active-low, [0] units, [1] tens, [2] hundreds
//   o_Bcd    : committed BCD value {hundreds, tens, units}
//   o_Busy   : conversion in progress
// master = ALU side, slave = display stage.
interface alu_result_display_if;
    logic [7:0]  i_Result;
    logic [7:0]  o_Seg;
    logic [2:0]  o_Enable;
    logic [11:0] o_Bcd;
    logic        o_Busy;

    modport master (output i_Result, input o_Seg, o_Enable, o_Bcd, o_Busy);
    modport slave  (input i_Result, output o_Seg, o_Enable, o_Bcd, o_Busy);
endinterface

// File: rtl/bin_to_bcd.sv
// Sequential double-dabble converter, 8-bit binary to 3 BCD digits.
//   clk, rst : clock, synchronous active-high reset
//   start    : begin a conversion of bin (accepted only while idle)
//   bin      : binary value to convert
//   busy     : high in CONVERT and DONE
//   done     : high for the single DONE cycle; bcd is final then
//   bcd      : {hundreds, tens, units} from the shift register
//
// state      | meaning
// ST_IDLE    | waiting for start
// ST_CONVERT | one add-3/shift step per cycle, 8 steps
// ST_DONE    | result ready for the consumer to commit
module bin_to_bcd
    import alu_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    conv_state_t state;
    logic [19:0] sr;
    logic [2:0]  step;

    // Correct every BCD nibble that would overflow past 9 on the shift.
    function automatic logic [19:0] dabble(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (t[8 + 4*i +: 4] >= 4'd5)
                t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sr    <= '0;
            step  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sr    <= {12'b0, bin};
                        step  <= '0;
                        busy  <= 1'b1;
                        state <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    sr   <= dabble(sr);
                    step <= step + 3'd1;
                    if (step == 3'd7) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bcd = sr[19:8];

endmodule

// File: rtl/alu_result_display.sv
// Display stage for the ALU result: samples the result, converts it to BCD
// and multiplexes it onto a 3-digit common-anode seven-segment display.
//   i_Clk, i_Rst : clock, synchronous active-high reset
//   bus          : alu_result_display_if slave (result in, display/BCD/busy out)
// REFRESH_DIV is the number of cycles each digit stays enabled (>= 2);
// BLANK_LZ = 1 blanks leading zeros.
module alu_result_display
    import alu_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
)(
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    alu_result_display_if.slave  bus
);

    localparam int         CNT_W      = $clog2(REFRESH_DIV);
    localparam logic [1:0] LAST_DIGIT = 2'(NUM_DIGITS - 1);

    logic [7:0]       r_Sample;
    logic [7:0]       r_Last;
    logic [11:0]      r_Bcd;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_idx;
    logic [7:0]       seg_q;
    logic [2:0]       enable_q;

    logic        start;
    logic        conv_busy;
    logic        conv_done;
    logic [11:0] conv_bcd;

    assign start = (r_Sample != r_Last);

    bin_to_bcd u_bin_to_bcd (
        .clk   (i_Clk),
        .rst   (i_Rst),
        .start (start),
        .bin   (r_Sample),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // r_Last only moves when the engine accepts a value, so a change that
    // arrives mid-conversion is picked up once the engine returns to idle.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Sample <= '0;
            r_Last   <= '0;
            r_Bcd    <= '0;
        end else begin
            r_Sample <= bus.i_Result;
            if (start && !conv_busy)
                r_Last <= r_Sample;
            if (conv_done)
                r_Bcd <= conv_bcd;
        end
    end

    logic [3:0] nib;
    logic       blank;

    always_comb begin
        nib   = r_Bcd[3:0];
        blank = 1'b0;
        case (digit_idx)
            2'd1: begin
                nib   = r_Bcd[7:4];
                blank = BLANK_LZ && (r_Bcd[11:8] == 4'd0) && (r_Bcd[7:4] == 4'd0);
            end
            2'd2: begin
                nib   = r_Bcd[11:8];
                blank = BLANK_LZ && (r_Bcd[11:8] == 4'd0);
            end
            default: ;
        endcase
    end

    // Segments and enable are both registered from the same digit_idx, so
    // they always change together.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            seg_q       <= SEG_BLANK;
            enable_q    <= 3'b111;
        end else begin
            if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= (digit_idx == LAST_DIGIT) ? 2'd0 : digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            enable_q <= ~(3'b001 << digit_idx);
            seg_q    <= blank ? SEG_BLANK : seg_decode(nib);
        end
    end

    assign bus.o_Seg    = seg_q;
    assign bus.o_Enable = enable_q;
    assign bus.o_Bcd    = r_Bcd;
    assign bus.o_Busy   = conv_busy;

endmodule
